led_pattern_sequencer: RTL and testbench

- Downstream of the board's 50 MHz blink/tick divider; consumes its one-cycle TICK strobe and drives the LED bank with one of four selectable patterns.
- A raw pushbutton is synchronised, debounced and edge-detected on-chip; each press advances the pattern mode.
- Replaces the fixed LED0/LED1/LED2 assignments at the board top level.

---
 rtl/led_pattern_sequencer.sv | 120 ++++++++++++
 tb/tb_led_pattern_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: a debounced pushbutton steps through four LED patterns,
// and the upstream TICK strobe advances the active pattern.
module led_pattern_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int N_LED           = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TICK,
  input  logic             BTN,
  output logic [N_LED-1:0] LED,
  output logic [1:0]       MODE,
  output logic             PRESS
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BINARY = 2'd3
  } mode_t;

  logic             sync1_q, sync1_d;
  logic             s_q, s_d;
  logic             db_q, db_d;
  logic             db_dly_q, db_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  mode_t            mode_q, mode_d;
  logic [N_LED-1:0] pat_q, pat_d;
  logic             dir_up_q, dir_up_d;
  logic             press_evt;
  logic [N_LED-1:0] shift_nxt;

  always_comb begin
    sync1_d   = BTN;
    s_d       = sync1_q;
    db_d      = db_q;
    cnt_d     = cnt_q;
    db_dly_d  = db_q;
    mode_d    = mode_q;
    pat_d     = pat_q;
    dir_up_d  = dir_up_q;
    shift_nxt = pat_q;

    // Debounce stage: the synchronised level must hold for the full count.
    if (s_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      db_d  = s_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    press_evt = db_q & ~db_dly_q;
    press_d   = press_evt;

    // Pattern stage: a press reloads the entry value and swallows any TICK.
    if (press_evt) begin
      mode_d = mode_t'(mode_q + 2'd1);
      case (mode_d)
        MODE_CHASE:  pat_d = N_LED'(1);
        MODE_BOUNCE: begin
          pat_d    = N_LED'(1);
          dir_up_d = 1'b1;
        end
        default:     pat_d = '0;
      endcase
    end else if (TICK) begin
      case (mode_q)
        MODE_BLINK:  pat_d = ~pat_q;
        MODE_CHASE:  pat_d = {pat_q[N_LED-2:0], pat_q[N_LED-1]};
        MODE_BOUNCE: begin
          if (dir_up_q) begin
            shift_nxt = {pat_q[N_LED-2:0], 1'b0};
            if (shift_nxt[N_LED-1]) dir_up_d = 1'b0;
          end else begin
            shift_nxt = {1'b0, pat_q[N_LED-1:1]};
            if (shift_nxt[0]) dir_up_d = 1'b1;
          end
          pat_d = shift_nxt;
        end
        default:     pat_d = pat_q + N_LED'(1);
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q  <= 1'b0;
      s_q      <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
      mode_q   <= MODE_BLINK;
      pat_q    <= '0;
      dir_up_q <= 1'b1;
    end else begin
      sync1_q  <= sync1_d;
      s_q      <= s_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      mode_q   <= mode_d;
      pat_q    <= pat_d;
      dir_up_q <= dir_up_d;
    end
  end

  assign LED   = pat_q;
  assign MODE  = mode_q;
  assign PRESS = press_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with a short debounce window.
module tb_led_pattern_sequencer;

  localparam int DB = 4;
  localparam int NL = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          TICK;
  logic          BTN;
  logic [NL-1:0] LED;
  logic [1:0]    MODE;
  logic          PRESS;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  led_pattern_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .N_LED(NL)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .TICK(TICK),
    .BTN(BTN),
    .LED(LED),
    .MODE(MODE),
    .PRESS(PRESS)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick_expect(input string tag, input logic [NL-1:0] exp_led, input logic [1:0] exp_mode);
    TICK = 1'b1;
    step();
    TICK = 1'b0;
    chk(tag, 32'(LED), 32'(exp_led));
    chk({tag, "_mode"}, 32'(MODE), 32'(exp_mode));
  endtask

  // BTN goes high just after edge 0; the press must surface after edge DB+3.
  task automatic press_release(input string tag, input logic [1:0] old_mode,
                               input logic [1:0] new_mode, input logic [NL-1:0] new_led,
                               input bit tick_at_evt);
    int presses;
    presses = 0;
    BTN = 1'b1;
    for (int e = 1; e <= DB + 2; e++) begin
      step();
      if (PRESS) presses++;
    end
    chk({tag, "_early_press"}, 32'(presses), 32'd0);
    chk({tag, "_mode_before"}, 32'(MODE), 32'(old_mode));
    if (tick_at_evt) TICK = 1'b1;
    step();
    TICK = 1'b0;
    chk({tag, "_press"}, 32'(PRESS), 32'd1);
    chk({tag, "_mode"}, 32'(MODE), 32'(new_mode));
    chk({tag, "_led"}, 32'(LED), 32'(new_led));
    step();
    chk({tag, "_press_one_cycle"}, 32'(PRESS), 32'd0);
    BTN = 1'b0;
    presses = 0;
    for (int e = 0; e < 10; e++) begin
      step();
      if (PRESS) presses++;
    end
    chk({tag, "_release_no_press"}, 32'(presses), 32'd0);
    chk({tag, "_mode_after_release"}, 32'(MODE), 32'(new_mode));
  endtask

  initial begin
    int presses;
    RST  = 1'b1;
    TICK = 1'b1;
    BTN  = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_led", 32'(LED), 32'd0);
      chk("rst_mode", 32'(MODE), 32'd0);
      chk("rst_press", 32'(PRESS), 32'd0);
    end

    RST  = 1'b0;
    TICK = 1'b0;
    BTN  = 1'b0;
    step();
    step();

    tick_expect("blink1", 3'b111, 2'd0);
    tick_expect("blink2", 3'b000, 2'd0);
    tick_expect("blink3", 3'b111, 2'd0);

    // A pulse one cycle short of the debounce window must vanish.
    presses = 0;
    BTN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (PRESS) presses++;
    end
    BTN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (PRESS) presses++;
    end
    chk("glitch_no_press", 32'(presses), 32'd0);
    chk("glitch_mode", 32'(MODE), 32'd0);
    chk("glitch_led", 32'(LED), 32'd7);

    press_release("press1", 2'd0, 2'd1, 3'b001, 1'b0);
    tick_expect("chase1", 3'b010, 2'd1);
    tick_expect("chase2", 3'b100, 2'd1);
    tick_expect("chase3", 3'b001, 2'd1);
    tick_expect("chase4", 3'b010, 2'd1);

    press_release("press2", 2'd1, 2'd2, 3'b001, 1'b0);
    tick_expect("bounce1", 3'b010, 2'd2);
    tick_expect("bounce2", 3'b100, 2'd2);
    tick_expect("bounce3", 3'b010, 2'd2);
    tick_expect("bounce4", 3'b001, 2'd2);
    tick_expect("bounce5", 3'b010, 2'd2);
    tick_expect("bounce6", 3'b100, 2'd2);

    press_release("press3", 2'd2, 2'd3, 3'b000, 1'b0);
    for (int i = 1; i <= 7; i++) tick_expect("binary", NL'(i), 2'd3);
    tick_expect("binary_wrap", 3'b000, 2'd3);
    tick_expect("binary_after_wrap", 3'b001, 2'd3);

    press_release("press4_wrap", 2'd3, 2'd0, 3'b000, 1'b0);
    press_release("press5", 2'd0, 2'd1, 3'b001, 1'b0);
    press_release("collision", 2'd1, 2'd2, 3'b001, 1'b1);

    // Reset lands with the debounce counter part-way through.
    BTN = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("mid_db_cnt", 32'(dut.cnt_q), 32'd2);
    RST = 1'b1;
    BTN = 1'b0;
    step();
    RST = 1'b0;
    chk("mid_db_cnt_cleared", 32'(dut.cnt_q), 32'd0);
    chk("mid_db_led", 32'(LED), 32'd0);
    chk("mid_db_mode", 32'(MODE), 32'd0);
    presses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (PRESS) presses++;
    end
    chk("mid_db_no_press", 32'(presses), 32'd0);
    chk("mid_db_mode_hold", 32'(MODE), 32'd0);

    // Button held through reset deassert is counted from scratch.
    RST = 1'b1;
    BTN = 1'b1;
    step();
    RST = 1'b0;
    press_release("held_thru_rst", 2'd0, 2'd1, 3'b001, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
